// File: rtl/fp_pkg.sv
// Shared constants and helpers for the FP adder tree: word geometry, rounding
// constant, exception encodings, clog2 and a leading-zero encoder.
package fp_pkg;

  localparam int         FP_EXPONENT = 8;
  localparam int         FP_MANTISSA = 23;
  localparam int         FP_W        = FP_EXPONENT + FP_MANTISSA + 1;
  localparam int         FP_GUARD    = 2;
  localparam logic [1:0] FP_RND      = 2'b10;

  // ZERO: exponent field 0 (mantissa ignored). INF: all-ones exponent, zero mantissa.
  localparam int         FP_EXP_ZERO = 0;
  localparam int         FP_MAN_INF  = 0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Leading zeros of v[width-1:0]; returns width when that field is all zero.
  function automatic int lz_enc(input logic [63:0] v, input int width);
    int lz;
    lz = width;
    for (int i = 0; i < 64; i++) begin
      if (i < width && v[i]) lz = width - 1 - i;
    end
    return lz;
  endfunction

endpackage

// File: rtl/fp_add_core.sv
// Combinational two-operand FP add: hidden-1, two guard bits, +2'b10 rounding,
// flush-to-zero on underflow, saturate-to-inf on exponent overflow.
module fp_add_core
  import fp_pkg::*;
#(
  parameter int EXPONENT = FP_EXPONENT,
  parameter int MANTISSA = FP_MANTISSA
) (
  input  logic [EXPONENT+MANTISSA:0] i_a,
  input  logic [EXPONENT+MANTISSA:0] i_b,
  output logic [EXPONENT+MANTISSA:0] o_sum
);

  localparam int W    = EXPONENT + MANTISSA + 1;
  localparam int SW   = MANTISSA + 1 + FP_GUARD;
  localparam int AW   = MANTISSA + 6;
  localparam int LZW  = clog2(AW) + 1;
  localparam int EMAX = (1 << EXPONENT) - 1;

  logic                 w_swap;
  logic [EXPONENT-1:0]  w_ea, w_eb, w_emax, w_diff;
  logic [SW-1:0]        w_ma, w_mb, w_mbig, w_msml, w_mshf;
  logic                 w_sbig, w_ssml, w_sign, w_carry;
  logic signed [AW-1:0] w_vbig, w_vsml, w_vsum;
  logic [AW-1:0]        w_mag, w_norm, w_rnd;
  logic [LZW-1:0]       w_lz;
  logic [MANTISSA-1:0]  w_man;
  logic [FP_GUARD+2:0]  w_unused_rnd;
  int                   w_exp;

  assign w_ea = i_a[W-2 -: EXPONENT];
  assign w_eb = i_b[W-2 -: EXPONENT];

  always_comb begin
    w_ma = (w_ea == EXPONENT'(FP_EXP_ZERO)) ? '0 : {1'b1, i_a[MANTISSA-1:0], {FP_GUARD{1'b0}}};
    w_mb = (w_eb == EXPONENT'(FP_EXP_ZERO)) ? '0 : {1'b1, i_b[MANTISSA-1:0], {FP_GUARD{1'b0}}};

    w_swap = w_eb > w_ea;
    w_emax = w_swap ? w_eb : w_ea;
    w_diff = w_swap ? (w_eb - w_ea) : (w_ea - w_eb);
    w_mbig = w_swap ? w_mb : w_ma;
    w_msml = w_swap ? w_ma : w_mb;
    w_sbig = w_swap ? i_b[W-1] : i_a[W-1];
    w_ssml = w_swap ? i_a[W-1] : i_b[W-1];
    w_mshf = (int'(w_diff) >= SW) ? '0 : (w_msml >> w_diff);

    w_vbig = w_sbig ? -$signed({3'b000, w_mbig}) : $signed({3'b000, w_mbig});
    w_vsml = w_ssml ? -$signed({3'b000, w_mshf}) : $signed({3'b000, w_mshf});
    w_vsum = w_vbig + w_vsml;
    w_sign = w_vsum[AW-1];
    w_mag  = w_sign ? $unsigned(-w_vsum) : $unsigned(w_vsum);

    // lz is counted below the sign slot, so a no-carry sum gives lz=2 and a carry gives lz=1.
    w_lz   = LZW'(lz_enc(64'(w_mag), AW - 1));
    w_norm = w_mag << w_lz;
    w_rnd  = w_norm + (AW'(FP_RND) << FP_GUARD);
    {w_carry, w_unused_rnd[FP_GUARD+2], w_man, w_unused_rnd[FP_GUARD+1:0]} = w_rnd;
    w_exp  = int'(w_emax) + 2 - int'(w_lz) + int'(w_carry);

    if (w_mag == '0 || w_exp <= 0)
      o_sum = {w_sign, EXPONENT'(FP_EXP_ZERO), {MANTISSA{1'b0}}};
    else if (w_exp >= EMAX)
      o_sum = {w_sign, {EXPONENT{1'b1}}, MANTISSA'(FP_MAN_INF)};
    else
      o_sum = {w_sign, EXPONENT'(w_exp), w_man};
  end

endmodule

// File: rtl/fp_adder_tree_pipe.sv
// Pipelined NUM_IN-operand FP adder tree with ready/valid and global stall enable.
// Optional group accumulator after the tree is enabled by FP_ADDTREE_ACC_EN.
module fp_adder_tree_pipe
  import fp_pkg::*;
#(
  parameter int EXPONENT = FP_EXPONENT,
  parameter int MANTISSA = FP_MANTISSA,
  parameter int NUM_IN   = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [NUM_IN*(EXPONENT+MANTISSA+1)-1:0]  in_data,
  input  logic                                     in_last,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [EXPONENT+MANTISSA:0]               out_data
);

  localparam int W      = EXPONENT + MANTISSA + 1;
  localparam int LEVELS = clog2(NUM_IN);

  logic              w_en;
  logic [W-1:0]      w_sum  [NUM_IN-1];
  logic [W-1:0]      r_node [NUM_IN-1];
  logic [LEVELS-1:0] r_vld;
  logic [W-1:0]      w_tree_data;
  logic              w_tree_vld;

  assign w_en        = !out_valid || out_ready;
  assign in_ready    = w_en;
  assign w_tree_data = r_node[NUM_IN-2];
  assign w_tree_vld  = r_vld[LEVELS-1];

  // Adders of level L occupy r_node/w_sum indices [NUM_IN-2*(NUM_IN>>L) +: NUM_IN>>L].
  for (genvar gl = 1; gl <= LEVELS; gl++) begin : g_lvl
    localparam int BASE = NUM_IN - 2 * (NUM_IN >> gl);
    localparam int PREV = NUM_IN - 2 * (NUM_IN >> (gl - 1));
    for (genvar gj = 0; gj < (NUM_IN >> gl); gj++) begin : g_add
      logic [W-1:0] w_a, w_b;
      if (gl == 1) begin : g_in
        assign w_a = in_data[(2*gj)*W +: W];
        assign w_b = in_data[(2*gj+1)*W +: W];
      end else begin : g_mid
        assign w_a = r_node[PREV + 2*gj];
        assign w_b = r_node[PREV + 2*gj + 1];
      end
      fp_add_core #(.EXPONENT(EXPONENT), .MANTISSA(MANTISSA)) u_add (
        .i_a  (w_a),
        .i_b  (w_b),
        .o_sum(w_sum[BASE + gj])
      );
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_IN - 1; k++) r_node[k] <= '0;
      r_vld <= '0;
    end else if (w_en) begin
      r_node <= w_sum;
      r_vld  <= (r_vld << 1) | LEVELS'(in_valid);
    end
  end

`ifdef FP_ADDTREE_ACC_EN
  logic [LEVELS-1:0] r_last;
  logic [W-1:0]      r_acc, r_out_data, w_acc_sum;
  logic              r_out_valid;

  fp_add_core #(.EXPONENT(EXPONENT), .MANTISSA(MANTISSA)) u_acc (
    .i_a  (r_acc),
    .i_b  (w_tree_data),
    .o_sum(w_acc_sum)
  );

  // r_acc is zero at the start of every group, so 0 + tree_sum is the first-beat case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last      <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_en) begin
      r_last      <= (r_last << 1) | LEVELS'(in_last);
      r_out_valid <= w_tree_vld && r_last[LEVELS-1];
      if (w_tree_vld) begin
        if (r_last[LEVELS-1]) begin
          r_out_data <= w_acc_sum;
          r_acc      <= '0;
        end else begin
          r_acc      <= w_acc_sum;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
`else
  logic w_unused_last;
  assign w_unused_last = in_last;
  assign out_valid     = w_tree_vld;
  assign out_data      = w_tree_data;
`endif

endmodule

// File: doc/fp_adder_tree_pipe.md
Name: fp_adder_tree_pipe

Overview:
Pipelined, parametrised N-operand floating-point adder for the FC/conv datapath. It sums NUM_IN packed operands per beat in a balanced binary tree, with one register level per tree level. It uses the team's FP add semantics: hidden-1 mantissa, 2 guard bits, +2'b10 rounding, flush-to-zero, saturate-to-inf. A ready/valid handshake with backpressure lets it sit directly between the operand buffer and the output accumulator.

Parameters:
EXPONENT, 8, exponent width.
MANTISSA, 23, stored mantissa width; word width W = EXPONENT+MANTISSA+1.
NUM_IN, 4, operands per beat; power of 2, 2..32.
LEVELS, log2(NUM_IN), derived localparam; tree depth, not user-set.

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  reset, asynchronous, active-high.
in_valid  in  1  beat on in_data is valid.
in_ready  out  1  block accepts a beat this cycle.
in_data  in  NUM_IN*W  operand k at bits [k*W +: W].
in_last  in  1  last beat of an accumulation group; used only with FP_ADDTREE_ACC_EN.
out_valid  out  1  out_data holds a result.
out_ready  in  1  downstream accepts the result.
out_data  out  W  sum.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, all stage valid bits=0. in_ready=1 after reset, because the pipeline is empty.
- Operand pre-check: an operand with exponent field 0 is exact zero, whatever its mantissa.
- Tree level L (1..LEVELS) uses NUM_IN>>L adders. Each adder is combinational and feeds a stage register holding data plus a valid bit.
- Latency: LEVELS cycles from accepted beat to out_valid, for example 2 at NUM_IN=4. Throughput is 1 beat/cycle when not stalled.
- Handshake:
  - A beat is accepted when in_valid&&in_ready.
  - out_data/out_valid are held stable while out_valid&&!out_ready.
  - Global enable: en = !out_valid || out_ready. All stages advance only when en=1.
  - in_ready = en, combinational from out_ready.
  - Bubbles (invalid stages) propagate and are not squeezed out.
- Per-add arithmetic:
  - Align the smaller exponent with a right shift; shifts ≥ MANTISSA+3 give 0.
  - Form the signed sum in MANTISSA+6 bits, then normalise with leading-zero detect and left shift.
  - Round by adding 2'b10 at the guard position; exponent = max_exp + 2 − lz.
  - Exponent overflow: sign, all-ones exponent, zero mantissa (inf). Inf inputs are treated as ordinary large values; NaN is unsupported.
  - Underflow or zero mantissa gives exponent 0 and mantissa 0, with sign = sum sign, which is 0 for exact cancellation.
- Reset asserted mid-operation discards every in-flight beat; there is no partial output.
- Simultaneous accept at the input and drain at the output in one cycle is legal and required at full rate.

Optional Feature:
- Macro FP_ADDTREE_ACC_EN.
- Defined:
  - An extra accumulator stage after the tree: acc ← (first beat of group ? 0 : acc) + tree_sum, using the same add semantics.
  - out_valid is asserted only for the beat tagged in_last; in_last travels down the pipeline with the data. out_data is then the group total and acc clears.
  - Latency is LEVELS+1.
  - A group of length 1 (in_last on the first beat) outputs that beat's tree sum.
- Undefined: in_last is ignored, and every beat produces an output.

Decomposition:
- Package fp_pkg holds:
  - localparams for W, guard width (2) and rounding constant 2'b10;
  - the function clog2;
  - the leading-zero-encode function;
  - exception encodings: ZERO exponent = 0, INF exponent = all ones with zero mantissa.
- One sub-module fp_add_core: combinational 2-operand add with identical semantics, instantiated NUM_IN−1 times by a generate loop, plus once more for the accumulator.

Test Plan:
- NUM_IN=4, fp32, one beat {0x3F800000 ×4}, out_ready=1 → after 2 cycles out_valid=1, out_data=0x40800000 (4.0).
- {0x3F800000, 0xBF800000, 0x40000000, 0xC0000000} → out_data=0x00000000.
- {0x7F000000 ×4} → overflow, out_data=0x7F800000. {0x00000123, 0x3F800000, 0, 0} → 0x3F800000, because exponent-0 operands count as zero.
- Stream 8 beats back-to-back with out_ready held low for cycles 3–5:
  - in_ready drops with out_ready;
  - out_data is held during the stall;
  - all 8 results emerge in order with no loss or duplication.
- Assert rst during beat 2 of a 4-beat stream → out_valid=0 immediately and no stale result after release.
- With FP_ADDTREE_ACC_EN: 3 beats of {0x3F800000 ×4}, last tagged on beat 3 → a single output 0x41400000 (12.0) at cycle 3+LEVELS+1; beats 1–2 produce no out_valid.
